// File: rtl/subdiv_pkg.sv
// Shared constants and builder state encoding for the subdivision pipeline.
package subdiv_pkg;

    localparam int          ADDR_WIDTH         = 9;
    localparam logic [31:0] Q_ONE              = 32'h0001_0000;
    localparam int          MAX_NEIGHBOR_COUNT = 10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_FACE_RD,
        S_PAIR_SEL,
        S_CNT_RD,
        S_SCAN,
        S_APPEND_WR,
        S_CNT_WR,
        S_DONE
    } nb_state_e;

endpackage

// File: rtl/face_pair_gen.sv
// Holds the three vertex indices of the current face and walks the six
// ordered (owner, neighbor) pairs formed from them.
module face_pair_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_adv,
    input  logic        i_ld,
    input  logic [1:0]  i_ld_sel,
    input  logic [31:0] i_ld_data,
    output logic [31:0] o_owner,
    output logic [31:0] o_neighbor,
    output logic        o_last_pair
);

    logic [31:0] r_a, r_b, r_c;
    logic [2:0]  r_pair;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= '0;
            r_pair <= '0;
        end else begin
            if (i_ld) begin
                case (i_ld_sel)
                    2'd0:    r_a <= i_ld_data;
                    2'd1:    r_b <= i_ld_data;
                    default: r_c <= i_ld_data;
                endcase
            end
            if (i_clr)
                r_pair <= '0;
            else if (i_adv && !o_last_pair)
                r_pair <= r_pair + 3'd1;
        end
    end

    always_comb begin
        o_owner    = r_c;
        o_neighbor = r_b;
        case (r_pair)
            3'd0:    begin o_owner = r_a; o_neighbor = r_b; end
            3'd1:    begin o_owner = r_a; o_neighbor = r_c; end
            3'd2:    begin o_owner = r_b; o_neighbor = r_a; end
            3'd3:    begin o_owner = r_b; o_neighbor = r_c; end
            3'd4:    begin o_owner = r_c; o_neighbor = r_a; end
            default: begin o_owner = r_c; o_neighbor = r_b; end
        endcase
    end

    assign o_last_pair = (r_pair == 3'd5);

endmodule

// File: rtl/neighbor_builder.sv
// Builds per-vertex adjacency records in the neighbor RAM from the face list
// in the object RAM, de-duplicating entries and flagging overflow/bad indices.
module neighbor_builder #(
    parameter int MAX_NEIGHBOR_COUNT = subdiv_pkg::MAX_NEIGHBOR_COUNT,
    parameter int ADDR_WIDTH         = subdiv_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           vertex_count,
    input  logic [31:0]           face_count,
    input  logic [31:0]           RAM_OBJ_Do,
    input  logic [31:0]           RAM_NBR_Do,
    output logic                  RAM_OBJ_EN,
    output logic                  RAM_NBR_EN,
    output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
    output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
    output logic [3:0]            RAM_OBJ_WE,
    output logic [3:0]            RAM_NBR_WE,
    output logic [31:0]           RAM_OBJ_Di,
    output logic [31:0]           RAM_NBR_Di,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  index_err
);
    import subdiv_pkg::*;

    localparam logic [31:0]           MAXW = 32'(MAX_NEIGHBOR_COUNT);
    localparam logic [ADDR_WIDTH-1:0] MAXA = ADDR_WIDTH'(MAX_NEIGHBOR_COUNT);

    nb_state_e             r_state;
    logic [31:0]           r_vcnt, r_fcnt, r_face, r_cnt, r_n;
    logic [ADDR_WIDTH-1:0] r_fbase, r_obase;

    logic [31:0]           w_owner, w_nbr;
    logic                  w_last_pair, w_ld, w_own_bad, w_nbr_bad, w_skip_idx;
    logic                  w_hit, w_scan_end, w_full, w_pair_done;
    logic [1:0]            w_ld_sel;
    logic [ADDR_WIDTH-1:0] w_obase;

    assign RAM_OBJ_WE = 4'b0000;
    assign RAM_OBJ_Di = 32'h0;

    assign w_ld     = (r_state == S_FACE_RD) && (r_cnt != 32'd0);
    assign w_ld_sel = r_cnt[1:0] - 2'd1;

    face_pair_gen u_pair (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (r_state == S_FACE_RD),
        .i_adv      (w_pair_done),
        .i_ld       (w_ld),
        .i_ld_sel   (w_ld_sel),
        .i_ld_data  (RAM_OBJ_Do),
        .o_owner    (w_owner),
        .o_neighbor (w_nbr),
        .o_last_pair(w_last_pair)
    );

    assign w_own_bad  = (w_owner == 32'd0) || (w_owner > r_vcnt);
    assign w_nbr_bad  = (w_nbr == 32'd0) || (w_nbr > r_vcnt);
    assign w_skip_idx = w_own_bad || w_nbr_bad || (w_owner == w_nbr);
    assign w_obase    = (w_owner[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1)) * MAXA;

    // In SCAN, r_cnt is the entry index whose read data is on RAM_NBR_Do (0 = none yet)
    assign w_hit      = (r_cnt != 32'd0) && (RAM_NBR_Do == w_nbr);
    assign w_scan_end = (r_cnt == r_n);
    assign w_full     = (r_n >= MAXW - 32'd1);

    assign w_pair_done = ((r_state == S_PAIR_SEL) && w_skip_idx) ||
                         ((r_state == S_SCAN) && (w_hit || (w_scan_end && w_full))) ||
                         (r_state == S_CNT_WR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_vcnt     <= '0;
            r_fcnt     <= '0;
            r_face     <= '0;
            r_cnt      <= '0;
            r_n        <= '0;
            r_fbase    <= '0;
            r_obase    <= '0;
            RAM_OBJ_EN <= 1'b0;
            RAM_OBJ_A  <= '0;
            RAM_NBR_EN <= 1'b0;
            RAM_NBR_A  <= '0;
            RAM_NBR_WE <= 4'b0000;
            RAM_NBR_Di <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            index_err  <= 1'b0;
        end else begin
            RAM_OBJ_EN <= 1'b0;
            RAM_NBR_EN <= 1'b0;
            RAM_NBR_WE <= 4'b0000;
            done       <= 1'b0;

            case (r_state)
                S_IDLE: if (start) begin
                    r_vcnt    <= vertex_count;
                    r_fcnt    <= face_count;
                    r_face    <= '0;
                    r_fbase   <= vertex_count[ADDR_WIDTH-1:0] * ADDR_WIDTH'(3) + ADDR_WIDTH'(1);
                    overflow  <= 1'b0;
                    index_err <= 1'b0;
                    if (vertex_count == 32'd0) begin
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        busy       <= 1'b1;
                        RAM_NBR_EN <= 1'b1;
                        RAM_NBR_WE <= 4'b1111;
                        RAM_NBR_A  <= '0;
                        RAM_NBR_Di <= '0;
                        r_obase    <= MAXA;
                        r_cnt      <= 32'd1;
                        r_state    <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    if (r_cnt < r_vcnt) begin
                        RAM_NBR_EN <= 1'b1;
                        RAM_NBR_WE <= 4'b1111;
                        RAM_NBR_A  <= r_obase;
                        RAM_NBR_Di <= '0;
                        r_obase    <= r_obase + MAXA;
                        r_cnt      <= r_cnt + 32'd1;
                    end else if (r_fcnt == 32'd0) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        RAM_OBJ_EN <= 1'b1;
                        RAM_OBJ_A  <= r_fbase;
                        r_cnt      <= '0;
                        r_state    <= S_FACE_RD;
                    end
                end

                // Three pipelined reads; word k is captured at the end of cycle k+1
                S_FACE_RD: begin
                    if (r_cnt < 32'd2) begin
                        RAM_OBJ_EN <= 1'b1;
                        RAM_OBJ_A  <= RAM_OBJ_A + ADDR_WIDTH'(1);
                    end
                    if (r_cnt == 32'd3)
                        r_state <= S_PAIR_SEL;
                    else
                        r_cnt <= r_cnt + 32'd1;
                end

                S_PAIR_SEL: begin
                    if (w_skip_idx) begin
                        if (w_own_bad || w_nbr_bad)
                            index_err <= 1'b1;
                    end else begin
                        RAM_NBR_EN <= 1'b1;
                        RAM_NBR_A  <= w_obase;
                        r_obase    <= w_obase;
                        r_cnt      <= '0;
                        r_state    <= S_CNT_RD;
                    end
                end

                S_CNT_RD: begin
                    if (r_cnt == 32'd0) begin
                        r_cnt <= 32'd1;
                    end else begin
                        r_n     <= RAM_NBR_Do;
                        r_cnt   <= '0;
                        r_state <= S_SCAN;
                        if (RAM_NBR_Do != 32'd0) begin
                            RAM_NBR_EN <= 1'b1;
                            RAM_NBR_A  <= r_obase + ADDR_WIDTH'(1);
                        end
                    end
                end

                S_SCAN: begin
                    if (!w_hit) begin
                        if (w_scan_end) begin
                            if (w_full) begin
                                overflow <= 1'b1;
                            end else begin
                                RAM_NBR_EN <= 1'b1;
                                RAM_NBR_WE <= 4'b1111;
                                RAM_NBR_A  <= r_obase + r_n[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
                                RAM_NBR_Di <= w_nbr;
                                r_state    <= S_APPEND_WR;
                            end
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                            if (r_cnt + 32'd2 <= r_n) begin
                                RAM_NBR_EN <= 1'b1;
                                RAM_NBR_A  <= RAM_NBR_A + ADDR_WIDTH'(1);
                            end
                        end
                    end
                end

                S_APPEND_WR: begin
                    RAM_NBR_EN <= 1'b1;
                    RAM_NBR_WE <= 4'b1111;
                    RAM_NBR_A  <= r_obase;
                    RAM_NBR_Di <= r_n + 32'd1;
                    r_state    <= S_CNT_WR;
                end

                S_CNT_WR: ;

                S_DONE: r_state <= S_IDLE;

                default: r_state <= S_IDLE;
            endcase

            // Common pair/face advance; overrides the per-state next-state above
            if (w_pair_done) begin
                if (!w_last_pair) begin
                    r_state <= S_PAIR_SEL;
                end else if (r_face + 32'd1 >= r_fcnt) begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end else begin
                    r_face     <= r_face + 32'd1;
                    r_fbase    <= r_fbase + ADDR_WIDTH'(3);
                    RAM_OBJ_EN <= 1'b1;
                    RAM_OBJ_A  <= r_fbase + ADDR_WIDTH'(3);
                    r_cnt      <= '0;
                    r_state    <= S_FACE_RD;
                end
            end
        end
    end

endmodule

// File: tb/tb_neighbor_builder.sv
// Directed bench for neighbor_builder with behavioural 1-cycle-latency RAMs.
module tb_neighbor_builder;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   vertex_count = '0;
    logic [31:0]   face_count = '0;
    logic [31:0]   RAM_OBJ_Do = '0;
    logic [31:0]   RAM_NBR_Do = '0;
    logic          RAM_OBJ_EN, RAM_NBR_EN;
    logic [AW-1:0] RAM_OBJ_A, RAM_NBR_A;
    logic [3:0]    RAM_OBJ_WE, RAM_NBR_WE;
    logic [31:0]   RAM_OBJ_Di, RAM_NBR_Di;
    logic          busy, done, overflow, index_err;

    logic [31:0] obj_mem [0:511];
    logic [31:0] nbr_mem [0:511];

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int nbr_wr_cnt = 0;
    int en_viol = 0;

    neighbor_builder #(.MAX_NEIGHBOR_COUNT(10), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .vertex_count(vertex_count), .face_count(face_count),
        .RAM_OBJ_Do(RAM_OBJ_Do), .RAM_NBR_Do(RAM_NBR_Do),
        .RAM_OBJ_EN(RAM_OBJ_EN), .RAM_NBR_EN(RAM_NBR_EN),
        .RAM_OBJ_A(RAM_OBJ_A), .RAM_NBR_A(RAM_NBR_A),
        .RAM_OBJ_WE(RAM_OBJ_WE), .RAM_NBR_WE(RAM_NBR_WE),
        .RAM_OBJ_Di(RAM_OBJ_Di), .RAM_NBR_Di(RAM_NBR_Di),
        .busy(busy), .done(done), .overflow(overflow), .index_err(index_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (RAM_OBJ_EN) RAM_OBJ_Do <= obj_mem[RAM_OBJ_A];
        if (RAM_NBR_EN) begin
            if (RAM_NBR_WE == 4'hF) nbr_mem[RAM_NBR_A] <= RAM_NBR_Di;
            RAM_NBR_Do <= nbr_mem[RAM_NBR_A];
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (RAM_NBR_WE != 4'h0) begin
                nbr_wr_cnt++;
                if (!RAM_NBR_EN) en_viol++;
            end
            if (RAM_OBJ_WE != 4'h0 || RAM_OBJ_Di != 32'h0) en_viol++;
        end
    end

    task automatic load_mesh(input int v, input int fl[$]);
        for (int i = 0; i < 512; i++) begin
            obj_mem[i] = 32'h0;
            nbr_mem[i] = 32'hDEAD_BEEF;
        end
        for (int i = 1; i <= 3 * v; i++) obj_mem[i] = 32'(i * 7);
        foreach (fl[i]) obj_mem[3 * v + 1 + i] = 32'(fl[i]);
    endtask

    task automatic run_build(input int v, input int f, output bit tmo, output logic b1, output int nd);
        int d0;
        int cyc;
        @(negedge clk);
        vertex_count = 32'(v);
        face_count   = 32'(f);
        start        = 1'b1;
        d0           = done_cnt;
        @(negedge clk);
        start = 1'b0;
        b1    = busy;
        cyc   = 0;
        tmo   = 1'b0;
        while (done_cnt == d0 && !tmo) begin
            @(negedge clk);
            cyc++;
            if (cyc > 4000) tmo = 1'b1;
        end
        repeat (4) @(negedge clk);
        nd = done_cnt - d0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, done, overflow, index_err, RAM_OBJ_EN, RAM_NBR_EN} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags got %b want 000000", {busy, done, overflow, index_err, RAM_OBJ_EN, RAM_NBR_EN});
        end
        n_vec++;
        if ({RAM_OBJ_A, RAM_NBR_A, RAM_OBJ_WE, RAM_NBR_WE, RAM_OBJ_Di, RAM_NBR_Di} !== '0) begin
            n_err++;
            $display("FAIL reset_bus got A=%h/%h WE=%h/%h Di=%h/%h want all 0",
                     RAM_OBJ_A, RAM_NBR_A, RAM_OBJ_WE, RAM_NBR_WE, RAM_OBJ_Di, RAM_NBR_Di);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_triangle();
        int fl[$];
        int ea[$];
        int ev[$];
        bit tmo; logic b1; int nd;
        fl = '{1, 2, 3};
        load_mesh(3, fl);
        run_build(3, 1, tmo, b1, nd);
        n_vec++;
        if (tmo || nd !== 1) begin n_err++; $display("FAIL tri_done got %0d pulses (timeout=%0d) want 1", nd, tmo); end
        n_vec++;
        if (b1 !== 1'b1) begin n_err++; $display("FAIL tri_busy_rise got %b want 1", b1); end
        n_vec++;
        if ({busy, overflow, index_err} !== 3'b000) begin
            n_err++; $display("FAIL tri_flags got %b want 000", {busy, overflow, index_err});
        end
        ea = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
        ev = '{2, 2, 3, 2, 1, 3, 2, 1, 2};
        foreach (ea[i]) begin
            n_vec++;
            if (nbr_mem[ea[i]] !== 32'(ev[i])) begin
                n_err++; $display("FAIL tri_word[%0d] got %0d want %0d", ea[i], nbr_mem[ea[i]], ev[i]);
            end
        end
    endtask

    task automatic test_shared_edge();
        int fl[$];
        int ea[$];
        int ev[$];
        bit tmo; logic b1; int nd;
        fl = '{1, 2, 3, 1, 3, 4};
        load_mesh(4, fl);
        run_build(4, 2, tmo, b1, nd);
        n_vec++;
        if (tmo || nd !== 1) begin n_err++; $display("FAIL shared_done got %0d pulses (timeout=%0d) want 1", nd, tmo); end
        ea = '{0, 1, 2, 3, 10, 11, 12, 20, 21, 22, 23, 30, 31, 32};
        ev = '{3, 2, 3, 4, 2, 1, 3, 3, 1, 2, 4, 2, 1, 3};
        foreach (ea[i]) begin
            n_vec++;
            if (nbr_mem[ea[i]] !== 32'(ev[i])) begin
                n_err++; $display("FAIL shared_word[%0d] got %0d want %0d", ea[i], nbr_mem[ea[i]], ev[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int fl[$];
        int ea[$];
        int ev[$];
        bit tmo; logic b1; int nd;
        for (int k = 2; k <= 11; k++) begin
            fl.push_back(1); fl.push_back(k); fl.push_back(k + 1);
        end
        load_mesh(12, fl);
        run_build(12, 10, tmo, b1, nd);
        n_vec++;
        if (tmo || nd !== 1) begin n_err++; $display("FAIL fan_done got %0d pulses (timeout=%0d) want 1", nd, tmo); end
        n_vec++;
        if ({overflow, index_err} !== 2'b10) begin
            n_err++; $display("FAIL fan_flags got ovf=%b idx=%b want ovf=1 idx=0", overflow, index_err);
        end
        ea = '{0, 1, 5, 9, 10, 11, 12, 50, 51, 52, 53, 100, 101, 102, 103, 110, 111, 112};
        ev = '{9, 2, 6, 10, 2, 1, 3, 3, 1, 5, 7, 3, 1, 10, 12, 2, 1, 11};
        foreach (ea[i]) begin
            n_vec++;
            if (nbr_mem[ea[i]] !== 32'(ev[i])) begin
                n_err++; $display("FAIL fan_word[%0d] got %0d want %0d", ea[i], nbr_mem[ea[i]], ev[i]);
            end
        end
    endtask

    task automatic test_index_err();
        int fl[$];
        int ea[$];
        int ev[$];
        bit tmo; logic b1; int nd;
        fl = '{1, 0, 2};
        load_mesh(2, fl);
        run_build(2, 1, tmo, b1, nd);
        n_vec++;
        if (tmo || nd !== 1) begin n_err++; $display("FAIL idx_done got %0d pulses (timeout=%0d) want 1", nd, tmo); end
        n_vec++;
        if ({overflow, index_err} !== 2'b01) begin
            n_err++; $display("FAIL idx_flags got ovf=%b idx=%b want ovf=0 idx=1", overflow, index_err);
        end
        ea = '{0, 1, 10, 11};
        ev = '{1, 2, 1, 1};
        foreach (ea[i]) begin
            n_vec++;
            if (nbr_mem[ea[i]] !== 32'(ev[i])) begin
                n_err++; $display("FAIL idx_word[%0d] got %0d want %0d", ea[i], nbr_mem[ea[i]], ev[i]);
            end
        end
    endtask

    task automatic test_clear_only();
        int fl[$];
        int w0;
        bit tmo; logic b1; int nd;
        fl = '{};
        load_mesh(3, fl);
        w0 = nbr_wr_cnt;
        run_build(3, 0, tmo, b1, nd);
        n_vec++;
        if (tmo || nd !== 1) begin n_err++; $display("FAIL clr_done got %0d pulses (timeout=%0d) want 1", nd, tmo); end
        n_vec++;
        if (nbr_wr_cnt - w0 !== 3) begin n_err++; $display("FAIL clr_writes got %0d want 3", nbr_wr_cnt - w0); end
        n_vec++;
        if ({nbr_mem[0], nbr_mem[10], nbr_mem[20]} !== 96'h0) begin
            n_err++; $display("FAIL clr_counts got %h %h %h want 0 0 0", nbr_mem[0], nbr_mem[10], nbr_mem[20]);
        end
        n_vec++;
        if (nbr_mem[1] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL clr_untouched got %h want deadbeef", nbr_mem[1]); end
    endtask

    task automatic test_vzero();
        int fl[$];
        int w0;
        bit tmo; logic b1; int nd;
        fl = '{1, 2, 3};
        load_mesh(0, fl);
        w0 = nbr_wr_cnt;
        run_build(0, 1, tmo, b1, nd);
        n_vec++;
        if (tmo || nd !== 1) begin n_err++; $display("FAIL v0_done got %0d pulses (timeout=%0d) want 1", nd, tmo); end
        n_vec++;
        if (nbr_wr_cnt - w0 !== 0) begin n_err++; $display("FAIL v0_writes got %0d want 0", nbr_wr_cnt - w0); end
    endtask

    task automatic test_reset_mid();
        int fl[$];
        int ea[$];
        int ev[$];
        bit tmo; logic b1; int nd;
        fl = '{1, 2, 3};
        load_mesh(3, fl);
        @(negedge clk);
        vertex_count = 32'd3; face_count = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, overflow, index_err, RAM_OBJ_EN, RAM_NBR_EN, RAM_NBR_WE, RAM_OBJ_A, RAM_NBR_A, RAM_NBR_Di} !== '0) begin
            n_err++;
            $display("FAIL midrst_outputs got busy=%b done=%b nEN=%b nWE=%h oA=%h nA=%h nDi=%h want all 0",
                     busy, done, RAM_NBR_EN, RAM_NBR_WE, RAM_OBJ_A, RAM_NBR_A, RAM_NBR_Di);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_build(3, 1, tmo, b1, nd);
        n_vec++;
        if (tmo || nd !== 1) begin n_err++; $display("FAIL midrst_done got %0d pulses (timeout=%0d) want 1", nd, tmo); end
        ea = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
        ev = '{2, 2, 3, 2, 1, 3, 2, 1, 2};
        foreach (ea[i]) begin
            n_vec++;
            if (nbr_mem[ea[i]] !== 32'(ev[i])) begin
                n_err++; $display("FAIL midrst_word[%0d] got %0d want %0d", ea[i], nbr_mem[ea[i]], ev[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int fl[$];
        int d0;
        int cyc;
        bit tmo;
        fl = '{1, 2, 3};
        load_mesh(3, fl);
        d0 = done_cnt;
        @(negedge clk);
        vertex_count = 32'd3; face_count = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; tmo = 1'b0;
        while (done_cnt == d0 && !tmo) begin
            @(negedge clk);
            cyc++;
            if (cyc > 4000) tmo = 1'b1;
        end
        repeat (60) @(negedge clk);
        n_vec++;
        if (tmo || done_cnt - d0 !== 1) begin
            n_err++; $display("FAIL b2b_done got %0d pulses (timeout=%0d) want 1", done_cnt - d0, tmo);
        end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle got busy=%b want 0", busy); end
        n_vec++;
        if ({nbr_mem[0], nbr_mem[1], nbr_mem[2]} !== {32'd2, 32'd2, 32'd3}) begin
            n_err++; $display("FAIL b2b_v0 got %0d %0d %0d want 2 2 3", nbr_mem[0], nbr_mem[1], nbr_mem[2]);
        end
    endtask

    initial begin
        test_reset();
        test_triangle();
        test_shared_edge();
        test_overflow();
        test_index_err();
        test_clear_only();
        test_vzero();
        test_reset_mid();
        test_back_to_back();
        n_vec++;
        if (en_viol !== 0) begin n_err++; $display("FAIL en_we_rule got %0d violations want 0", en_viol); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
